// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_memory port between NUM_CORES requesting cores.
// Each transaction is issued from fields latched at grant time, and the granted
// core receives a one-cycle ack. Arbitration is round-robin by default. Define
// DMEM_ARB_FIXED_PRIO_EN to get fixed priority, where the lowest index wins.
module dmem_arbiter #(
  parameter int NUM_CORES  = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             RESET,
  input  logic [NUM_CORES-1:0]             req_read,
  input  logic [NUM_CORES-1:0]             req_write,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_CORES-1:0]             ack,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW   = ID_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      win_q;     // core being served
  logic [ID_W-1:0]      win_id;    // arbitration result in IDLE
  logic                 op_wr_q;   // latched operation: 1 = write
  logic [NUM_CORES-1:0] requesting;
  logic                 any_req;

  assign requesting = req_read | req_write;
  assign any_req    = |requesting;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest-index requesting core wins.
  always_comb begin
    win_id = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (requesting[i]) win_id = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] rr_q;
  logic [CW-1:0]   cand;
  logic            found;

  // Round-robin: take the first requester at or above the pointer, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    win_id = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cand = CW'(rr_q) + CW'(i);
      if (cand >= CW'(NUM_CORES)) cand = cand - CW'(NUM_CORES);
      if (!found && requesting[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        win_id = cand[ID_W-1:0];
      end
    end
  end

  // Move the pointer past the core that was just acknowledged.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      rr_q <= '0;
    end else if (state_q == ACK) begin
      rr_q <= (win_q == ID_W'(NUM_CORES - 1)) ? '0 : win_q + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the memory strobes, ack and busy decoded from the state.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ack       = '0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        if (op_wr_q) begin
          mem_write = 1'b1;
          state_d   = ACK;
        end else begin
          mem_read = 1'b1;
          state_d  = RWAIT;
        end
      end
      RWAIT: begin
        mem_read = 1'b1;
        state_d  = ACK;
      end
      ACK: begin
        ack[win_q] = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's fields at grant time and capture read data in RWAIT.
  // mem_addr and mem_wdata act as the latched fields, so they hold between grants.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      win_q     <= '0;
      op_wr_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        win_q    <= win_id;
        op_wr_q  <= req_write[win_id];
        mem_addr <= req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
        if (req_write[win_id]) mem_wdata <= req_wdata[win_id*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_q == RWAIT) rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It runs directed scenarios followed by randomized
// multi-core traffic. The random traffic is checked against a transaction-level
// reference model of arbitration order, latency and memory contents.
module tb_dmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            RESET;
  logic [N-1:0]    req_read, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy, mem_read, mem_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .RESET(RESET),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment data memory: a registered read, so data is valid the cycle after mem_read.
  logic [DW-1:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= env_mem[mem_addr[7:0]];
  end

  function automatic logic [DW-1:0] init_val(input int i);
    return 16'(i * 32'h0137) ^ 16'hA5A5;
  endfunction

  task automatic set_req(input int k, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[k]            = rd;
    req_write[k]           = wr;
    req_addr[k*AW +: AW]   = a;
    req_wdata[k*DW +: DW]  = d;
  endtask

  // Drives one request from an idle arbiter and reports the cycle of the ack.
  // The IDLE cycle that first sees the request counts as cycle 1.
  task automatic do_op(input int k, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit pulse,
                       output int lat, output logic [DW-1:0] rdv,
                       output bit saw_rd, output bit saw_wr, output bit strobe_bad);
    lat = -1; rdv = '0; saw_rd = 1'b0; saw_wr = 1'b0; strobe_bad = 1'b0;
    @(negedge clk);
    set_req(k, rd, wr, a, d);
    for (int n = 2; n <= 10; n++) begin
      @(negedge clk);
      if (pulse) set_req(k, 1'b0, 1'b0, a, d);
      saw_rd |= mem_read;
      saw_wr |= mem_write;
      if ((mem_read || mem_write) && (!busy || ack != '0)) strobe_bad = 1'b1;
      if (ack[k]) begin
        lat = n;
        rdv = rdata;
        break;
      end
    end
    set_req(k, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset;
    RESET = 1'b0;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    #12;
    n_cmp++; if ({ack, busy, mem_read, mem_write} !== '0) begin n_bad++;
      $display("FAIL reset_ctrl got ack=%b busy=%b mr=%b mw=%b want all 0", ack, busy, mem_read, mem_write); end
    n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got %h want 0000", rdata); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++;
      $display("FAIL reset_membus got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_contention;
    int got[$];
    int want[$];
    bit bad_strobe = 1'b0;
    bit bad_onehot = 1'b0;
    @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    want = '{0, 0, 0, 2};
    set_req(0, 1'b1, 1'b0, 16'h0030, '0);
    set_req(2, 1'b1, 1'b0, 16'h0032, '0);
`else
    want = '{0, 1, 2, 0};
    for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b0, 16'(16'h0030 + k), '0);
`endif
    for (int c = 0; c < 60 && got.size() < 4; c++) begin
      @(negedge clk);
      if ((mem_read || mem_write) && (!busy || ack != '0)) bad_strobe = 1'b1;
      if (!$onehot0(ack)) bad_onehot = 1'b1;
      for (int k = 0; k < N; k++) if (ack[k]) got.push_back(k);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (got.size() == 3) set_req(0, 1'b0, 1'b0, '0, '0);
`endif
    end
    req_read = '0; req_write = '0;
    n_cmp++; if (got.size() != 4) begin n_bad++;
      $display("FAIL contention_count got %0d acks want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++; if (got[i] != want[i]) begin n_bad++;
        $display("FAIL contention_order ack #%0d got core%0d want core%0d", i, got[i], want[i]); end
    end
    n_cmp++; if (bad_strobe) begin n_bad++; $display("FAIL contention_strobe mem strobe got 1 outside ISSUE/RWAIT want 0"); end
    n_cmp++; if (bad_onehot) begin n_bad++; $display("FAIL contention_onehot ack got multi-hot want one-hot"); end
  endtask

  task automatic test_write_read;
    int lat; logic [DW-1:0] rdv; bit sr, sw, sb;
    do_op(0, 1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, lat, rdv, sr, sw, sb);
    n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL wr_latency got %0d want 3", lat); end
    n_cmp++; if (sr || !sw || sb) begin n_bad++;
      $display("FAIL wr_strobes got rd=%b wr=%b bad=%b want 0 1 0", sr, sw, sb); end
    do_op(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, lat, rdv, sr, sw, sb);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rd_latency got %0d want 4", lat); end
    n_cmp++; if (rdv !== 16'h1234) begin n_bad++; $display("FAIL rd_data got %h want 1234", rdv); end
    n_cmp++; if (!sr || sw || sb) begin n_bad++;
      $display("FAIL rd_strobes got rd=%b wr=%b bad=%b want 1 0 0", sr, sw, sb); end
    repeat (3) @(negedge clk);
    n_cmp++; if (rdata !== 16'h1234) begin n_bad++; $display("FAIL rd_hold got %h want 1234", rdata); end
  endtask

  task automatic test_both_ops;
    int lat; logic [DW-1:0] rdv; bit sr, sw, sb;
    do_op(2, 1'b1, 1'b1, 16'h0007, 16'hBEEF, 1'b0, lat, rdv, sr, sw, sb);
    n_cmp++; if (lat != 3 || sr || !sw) begin n_bad++;
      $display("FAIL both_as_write got lat=%0d rd=%b wr=%b want 3 0 1", lat, sr, sw); end
    n_cmp++; if (mem_addr !== 16'h0007 || mem_wdata !== 16'hBEEF) begin n_bad++;
      $display("FAIL both_bus_hold got addr=%h wdata=%h want 0007 beef", mem_addr, mem_wdata); end
    do_op(1, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, lat, rdv, sr, sw, sb);
    n_cmp++; if (rdv !== 16'hBEEF) begin n_bad++; $display("FAIL both_readback got %h want beef", rdv); end
  endtask

  task automatic test_drop;
    int lat; logic [DW-1:0] rdv; bit sr, sw, sb;
    int extra = 0;
    do_op(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, lat, rdv, sr, sw, sb);
    n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL drop_latency got %0d want 4", lat); end
    n_cmp++; if (rdv !== init_val(16'h20)) begin n_bad++;
      $display("FAIL drop_data got %h want %h", rdv, init_val(16'h20)); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ack != '0) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL drop_single_ack got %0d extra acks want 0", extra); end
  endtask

  task automatic test_reset_mid_read;
    int acks = 0;
    int busy_cnt = 0;
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 16'h0010, '0);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (mem_read !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL rst_mid_pre got mr=%b busy=%b want 1 1", mem_read, busy); end
    RESET = 1'b0;
    #1;
    n_cmp++; if (mem_read !== 1'b0 || busy !== 1'b0 || ack !== '0) begin n_bad++;
      $display("FAIL rst_mid_async got mr=%b busy=%b ack=%b want 0 0 0", mem_read, busy, ack); end
    n_cmp++; if (rdata !== '0 || mem_addr !== '0) begin n_bad++;
      $display("FAIL rst_mid_regs got rdata=%h addr=%h want 0 0", rdata, mem_addr); end
    set_req(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    RESET = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != '0) acks++;
      if (busy) busy_cnt++;
    end
    n_cmp++; if (acks != 0 || busy_cnt != 0) begin n_bad++;
      $display("FAIL rst_mid_after got acks=%0d busy_cycles=%0d want 0 0", acks, busy_cnt); end
  endtask

  // Random multi-core traffic against a transaction-level model. A grant in
  // IDLE cycle g puts the ack in cycle g+2 for a write or g+3 for a read.
  // The arbiter is free again in the cycle after the ack.
  task automatic test_random;
    logic [DW-1:0] ref_mem [256];
    bit            pend [N];
    logic          c_rd [N], c_wr [N];
    logic [AW-1:0] c_addr [N];
    logic [DW-1:0] c_data [N];
    int grant_c = -100, ack_c = -100, free_c = 0;
    int w = 0, m_rr = 0;
    bit g_wr = 1'b0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] exp_val = '0, m_rdata = '0;
    logic [N-1:0]  exp_ack;
    bit exp_busy, exp_mr, exp_mw;
    int served = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      exp_busy = (c > grant_c) && (c <= ack_c);
      exp_ack  = (c == ack_c) ? N'(1 << w) : '0;
      exp_mr   = !g_wr && (c == grant_c + 1 || c == grant_c + 2);
      exp_mw   = g_wr && (c == grant_c + 1);
      if (c == ack_c && !g_wr) m_rdata = exp_val;
      n_cmp++; if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, exp_busy); end
      n_cmp++; if (ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack c=%0d got %b want %b", c, ack, exp_ack); end
      n_cmp++; if (rdata !== m_rdata) begin n_bad++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, rdata, m_rdata); end
      n_cmp++; if (mem_read !== exp_mr || mem_write !== exp_mw) begin n_bad++;
        $display("FAIL rnd_strobe c=%0d got mr=%b mw=%b want %b %b", c, mem_read, mem_write, exp_mr, exp_mw); end
      if (exp_mr || exp_mw) begin
        n_cmp++; if (mem_addr !== g_addr) begin n_bad++; $display("FAIL rnd_addr c=%0d got %h want %h", c, mem_addr, g_addr); end
      end
      if (c == ack_c) begin
        pend[w] = 1'b0;
        served++;
        set_req(w, 1'b0, 1'b0, '0, '0);
      end
      // Scramble the granted core's fields mid-transaction; the latched copy must win.
      if (c > grant_c && c < ack_c) begin
        req_addr[w*AW +: AW]  = 16'($urandom);
        req_wdata[w*DW +: DW] = 16'($urandom);
      end
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          int kind = $urandom_range(0, 3);
          pend[k]   = 1'b1;
          c_rd[k]   = (kind == 0 || kind == 1 || kind == 3);
          c_wr[k]   = (kind == 2 || kind == 3);
          c_addr[k] = 16'(16'h0040 + $urandom_range(0, 15));
          c_data[k] = 16'($urandom);
          set_req(k, c_rd[k], c_wr[k], c_addr[k], c_data[k]);
        end
      end
      if (c >= free_c) begin
        int pick = -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) if (pend[k]) pick = k;
`else
        for (int i = N - 1; i >= 0; i--) if (pend[(m_rr + i) % N]) pick = (m_rr + i) % N;
`endif
        if (pick >= 0) begin
          w       = pick;
          g_wr    = c_wr[w];
          g_addr  = c_addr[w];
          grant_c = c;
          ack_c   = c + (g_wr ? 2 : 3);
          free_c  = ack_c + 1;
          if (g_wr) ref_mem[g_addr[7:0]] = c_data[w];
          else      exp_val = ref_mem[g_addr[7:0]];
`ifndef DMEM_ARB_FIXED_PRIO_EN
          m_rr = (w + 1) % N;
`endif
        end
      end
    end
    n_cmp++; if (served < 50) begin n_bad++; $display("FAIL rnd_progress got %0d served want >= 50", served); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = init_val(i);
    test_reset;
    test_contention;
    test_write_read;
    test_both_ops;
    test_drop;
    test_reset_mid_read;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
